array_fifo_module: RTL and testbench
====================================

ARRAY_FIFO_MODULE -- requirements
Module: array_fifo_module

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of each channel element.
REQ-002 SHALL have parameter CHANNELS, default 2, number of parallel elements per entry.
REQ-003 SHALL have parameter DEPTH, default 4, entries stored; power of two, >= 2.
REQ-004 SHALL have parameter CONST_VAL, default 8'h3D (WIDTH bits), element value driven in constant mode.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port select_in  input  2  output mode: 0 pass, 1 constant, 2 bit-reversed, 3 treated as 0.
REQ-008 SHALL have port in_valid  input  1  producer offers an entry.
REQ-009 SHALL have port in_ready  output  1  block accepts an entry this cycle.
REQ-010 SHALL have port in_data  input  CHANNELS*WIDTH  entry; channel c at bits [c*WIDTH +: WIDTH].
REQ-011 SHALL have port out_valid  output  1  head entry available.
REQ-012 SHALL have port out_ready  input  1  consumer takes head entry.
REQ-013 SHALL have port out_data  output  CHANNELS*WIDTH  head entry after mode transform, same channel packing.
REQ-014 SHALL have port count_out  output  $clog2(DEPTH+1)  entries currently stored.
REQ-015 SHALL have port overflow_out  output  1  sticky flag: push attempted while full.

Function
REQ-016 SHALL store entries as a DEPTH x CHANNELS array of WIDTH-bit elements, FIFO order.
REQ-017 SHALL push when in_valid && in_ready at a rising edge; pop when out_valid && out_ready.
REQ-018 SHALL drive in_ready = (count_out < DEPTH), combinational from state only, never from in_valid.
REQ-019 SHALL drive out_valid = (count_out != 0), combinational from state only, never from out_ready.
REQ-020 SHALL give 1-cycle latency: entry pushed at edge N is presented with out_valid high after edge N; no same-cycle bypass when empty.
REQ-021 SHALL, on simultaneous push and pop (neither full nor empty), keep count_out unchanged and advance both pointers.
REQ-022 SHALL, when full, ignore in_valid (no write, data not corrupted); when empty, ignore out_ready (no pointer move).
REQ-023 SHALL wrap read and write pointers modulo DEPTH.
REQ-024 SHALL set overflow_out at the edge where in_valid is high and count_out == DEPTH; held until reset.
REQ-025 SHALL form out_data per channel from head entry: mode 0 element unchanged; mode 1 CONST_VAL; mode 2 element bit-reversed (bit i -> bit WIDTH-1-i).
REQ-026 SHALL apply select_in combinationally to the current head; changing mode does not alter stored data or pointers.
REQ-027 SHALL pop in every mode, including mode 1 (constant value still consumes the head entry).
REQ-028 SHALL drive out_data to all-zero when out_valid is low, regardless of mode.

Reset
REQ-029 SHALL, while rst high, clear pointers, count_out=0, overflow_out=0, giving in_ready=1, out_valid=0, out_data=0.
REQ-030 SHALL treat rst asserted mid-operation as an immediate flush; stored entries lost, no pop or push completes at that edge.
REQ-031 SHALL not require storage array contents to be reset.

Verification
REQ-032 SHALL cover, CHANNELS=2 WIDTH=8: push {8'hA5,8'h01} mode 0, out_ready=1 -> next cycle out_data {8'hA5,8'h01}, out_valid=1, then popped, count 1->0.
REQ-033 SHALL cover: push DEPTH=4 entries 1..4, no pop -> in_ready=0, count_out=4; fifth push attempt sets overflow_out=1; pops return 1,2,3,4 unaltered.
REQ-034 SHALL cover: head 8'h01 in mode 2 -> out element 8'h80; mode 1 -> 8'h3D; mode 3 -> 8'h01; count unchanged until out_ready.
REQ-035 SHALL cover: count_out=2, push and pop same edge for 6 cycles -> count stays 2, order preserved across pointer wrap.
REQ-036 SHALL cover: rst pulse asynchronously mid-stream with count_out=3 -> count_out=0, out_valid=0, overflow_out=0, in_ready=1 before next clk edge.
REQ-037 SHALL cover: empty FIFO, out_ready=1 held with no push -> no count underflow, out_data=0.

Source files
------------

// File: rtl/array_fifo_module.sv
// rtl/array_fifo_module.sv - multi-channel array FIFO with per-channel output transform
//
// Purpose:
//   Stores DEPTH entries, each CHANNELS elements of WIDTH bits, in FIFO order.
//   The head entry is presented through a combinational transform chosen by
//   select_in: pass-through, constant value, or per-element bit reversal.
//   Push and pop use valid/ready handshakes. A sticky flag records any push
//   attempted while full.
//
// Ports:
//   clk          in   rising-edge clock for all state
//   rst          in   asynchronous active-high reset; flushes the FIFO
//   select_in    in   [1:0] output mode: 0 pass, 1 constant, 2 bit-reversed, 3 pass
//   in_valid     in   producer offers an entry
//   in_ready     out  entry can be accepted this cycle (not full)
//   in_data      in   [CHANNELS*WIDTH-1:0] entry, channel c at [c*WIDTH +: WIDTH]
//   out_valid    out  head entry available (not empty)
//   out_ready    in   consumer takes the head entry
//   out_data     out  [CHANNELS*WIDTH-1:0] transformed head, zero when empty
//   count_out    out  [$clog2(DEPTH+1)-1:0] number of stored entries
//   overflow_out out  sticky: push attempted while full

module array_fifo_module #(
  parameter int               WIDTH     = 8,
  parameter int               CHANNELS  = 2,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(8'h3D)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  select_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CHANNELS*WIDTH-1:0]   in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CHANNELS*WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH+1)-1:0]  count_out,
  output logic                        overflow_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH][CHANNELS];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Handshake flags depend on stored state only, so no combinational path
  // exists from in_valid/out_ready to the ready/valid outputs.
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;

  assign w_push = in_valid && !w_full;
  assign w_pop  = out_ready && !w_empty;

  // Storage array carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_mem[r_wr_ptr][c] <= in_data[c*WIDTH +: WIDTH];
      end
    end
  end

  // DEPTH is a power of two, so natural pointer overflow gives the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (in_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign count_out    = r_count;
  assign overflow_out = r_overflow;

  // Output transform applied to the current head; mode 3 falls back to pass.
  always_comb begin
    out_data = '0;
    if (!w_empty) begin
      for (int c = 0; c < CHANNELS; c++) begin
        case (select_in)
          2'd1: out_data[c*WIDTH +: WIDTH] = CONST_VAL;
          2'd2: begin
            for (int i = 0; i < WIDTH; i++) begin
              out_data[c*WIDTH + i] = r_mem[r_rd_ptr][c][WIDTH-1-i];
            end
          end
          default: out_data[c*WIDTH +: WIDTH] = r_mem[r_rd_ptr][c];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_array_fifo_module.sv
// tb/tb_array_fifo_module.sv - self-checking bench for array_fifo_module
//
// Purpose:
//   Directed scenarios plus randomized traffic, compared against a queue-based
//   reference model of FIFO behaviour and the output transform.
//
// Ports: none (top-level bench).

module tb_array_fifo_module;

  localparam int W  = 8;
  localparam int C  = 2;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);
  localparam logic [W-1:0] K = 8'h3D;

  logic            clk;
  logic            rst;
  logic [1:0]      select_in;
  logic            in_valid;
  logic            in_ready;
  logic [C*W-1:0]  in_data;
  logic            out_valid;
  logic            out_ready;
  logic [C*W-1:0]  out_data;
  logic [CW-1:0]   count_out;
  logic            overflow_out;

  array_fifo_module #(.WIDTH(W), .CHANNELS(C), .DEPTH(D), .CONST_VAL(K)) dut (
    .clk          (clk),
    .rst          (rst),
    .select_in    (select_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .count_out    (count_out),
    .overflow_out (overflow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a plain queue of entries and a sticky overflow bit.
  logic [C*W-1:0] q[$];
  bit             m_ovf;

  function automatic logic [C*W-1:0] exp_out(input logic [1:0] mode);
    logic [C*W-1:0] r;
    logic [W-1:0]   e;
    r = '0;
    if (q.size() != 0) begin
      for (int c = 0; c < C; c++) begin
        e = q[0][c*W +: W];
        if (mode == 2'd1)      r[c*W +: W] = K;
        else if (mode == 2'd2) r[c*W +: W] = {<<{e}};
        else                   r[c*W +: W] = e;
      end
    end
    return r;
  endfunction

  // Advance one clock edge, updating the model from the inputs held for it.
  task automatic cycle();
    bit do_push;
    bit do_pop;
    logic [C*W-1:0] d;
    do_push = in_valid && (q.size() < D);
    do_pop  = out_ready && (q.size() != 0);
    d = in_data;
    if (in_valid && q.size() == D) m_ovf = 1'b1;
    @(posedge clk);
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(d);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; select_in = 2'd0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (count_out !== '0) $display("FAIL reset_count got %0d want 0", count_out); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL reset_out_data got %h want 0", out_data); else n_pass++;
    n_total++; if (overflow_out !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow_out); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    select_in = 2'd0; in_valid = 1'b1; out_ready = 1'b1; in_data = {8'hA5, 8'h01};
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL single_no_bypass got %b want 0", out_valid); else n_pass++;
    cycle();
    in_valid = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b1) $display("FAIL single_out_valid got %b want 1", out_valid); else n_pass++;
    n_total++; if (out_data !== 16'hA501) $display("FAIL single_out_data got %h want a501", out_data); else n_pass++;
    n_total++; if (count_out !== CW'(1)) $display("FAIL single_count1 got %0d want 1", count_out); else n_pass++;
    cycle();
    n_total++; if (count_out !== '0) $display("FAIL single_count0 got %0d want 0", count_out); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL single_drained got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_full_overflow();
    select_in = 2'd0; out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 1; i <= D; i++) begin
      in_data = (C*W)'(i);
      cycle();
    end
    n_total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b want 0", in_ready); else n_pass++;
    n_total++; if (count_out !== CW'(D)) $display("FAIL full_count got %0d want %0d", count_out, D); else n_pass++;
    n_total++; if (overflow_out !== 1'b0) $display("FAIL full_ovf_early got %b want 0", overflow_out); else n_pass++;
    in_data = (C*W)'(5);
    cycle();
    n_total++; if (overflow_out !== 1'b1) $display("FAIL full_ovf_set got %b want 1", overflow_out); else n_pass++;
    n_total++; if (count_out !== CW'(D)) $display("FAIL full_count_hold got %0d want %0d", count_out, D); else n_pass++;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= D; i++) begin
      #1;
      n_total++; if (out_data !== (C*W)'(i)) $display("FAIL full_pop_%0d got %h want %h", i, out_data, (C*W)'(i)); else n_pass++;
      cycle();
    end
    n_total++; if (count_out !== '0) $display("FAIL full_drained got %0d want 0", count_out); else n_pass++;
    n_total++; if (overflow_out !== 1'b1) $display("FAIL full_ovf_sticky got %b want 1", overflow_out); else n_pass++;
  endtask

  task automatic test_modes();
    out_ready = 1'b0; in_valid = 1'b1; select_in = 2'd0; in_data = {8'hF0, 8'h01};
    cycle();
    in_valid = 1'b0;
    select_in = 2'd2; #1;
    n_total++; if (out_data !== 16'h0F80) $display("FAIL mode2 got %h want 0f80", out_data); else n_pass++;
    select_in = 2'd1; #1;
    n_total++; if (out_data !== 16'h3D3D) $display("FAIL mode1 got %h want 3d3d", out_data); else n_pass++;
    select_in = 2'd3; #1;
    n_total++; if (out_data !== 16'hF001) $display("FAIL mode3 got %h want f001", out_data); else n_pass++;
    cycle();
    n_total++; if (count_out !== CW'(1)) $display("FAIL mode_count_hold got %0d want 1", count_out); else n_pass++;
    select_in = 2'd1; out_ready = 1'b1;
    cycle();
    n_total++; if (count_out !== '0) $display("FAIL mode1_pop got %0d want 0", count_out); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    select_in = 2'd0; out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = (C*W)'($urandom);
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = (C*W)'($urandom);
      #1;
      n_total++; if (out_data !== exp_out(select_in)) $display("FAIL b2b_data_%0d got %h want %h", i, out_data, exp_out(select_in)); else n_pass++;
      cycle();
      n_total++; if (count_out !== CW'(2)) $display("FAIL b2b_count_%0d got %0d want 2", i, count_out); else n_pass++;
    end
    in_valid = 1'b0;
    cycle(); cycle();
  endtask

  task automatic test_async_reset();
    select_in = 2'd0; out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = (C*W)'($urandom);
      cycle();
    end
    in_valid = 1'b1; in_data = (C*W)'(7);
    cycle();
    in_data = (C*W)'(8);
    cycle();
    in_valid = 1'b0;
    n_total++; if (overflow_out !== 1'b1) $display("FAIL arst_pre_ovf got %b want 1", overflow_out); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (count_out !== '0) $display("FAIL arst_count got %0d want 0", count_out); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (overflow_out !== 1'b0) $display("FAIL arst_ovf got %b want 0", overflow_out); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL arst_in_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL arst_out_data got %h want 0", out_data); else n_pass++;
    #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_empty_pop();
    in_valid = 1'b0; out_ready = 1'b1; select_in = 2'd1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_total++; if (count_out !== '0) $display("FAIL empty_count_%0d got %0d want 0", i, count_out); else n_pass++;
      n_total++; if (out_data !== '0) $display("FAIL empty_data_%0d got %h want 0", i, out_data); else n_pass++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 99) < 55);
      out_ready = ($urandom_range(0, 99) < 45);
      select_in = 2'($urandom);
      in_data   = (C*W)'($urandom);
      #1;
      n_total++; if (count_out !== CW'(q.size())) $display("FAIL rnd_count_%0d got %0d want %0d", i, count_out, q.size()); else n_pass++;
      n_total++; if (in_ready !== (q.size() < D)) $display("FAIL rnd_in_ready_%0d got %b", i, in_ready); else n_pass++;
      n_total++; if (out_valid !== (q.size() != 0)) $display("FAIL rnd_out_valid_%0d got %b", i, out_valid); else n_pass++;
      n_total++; if (out_data !== exp_out(select_in)) $display("FAIL rnd_data_%0d got %h want %h", i, out_data, exp_out(select_in)); else n_pass++;
      n_total++; if (overflow_out !== m_ovf) $display("FAIL rnd_ovf_%0d got %b want %b", i, overflow_out, m_ovf); else n_pass++;
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_overflow();
    test_modes();
    test_back_to_back();
    test_async_reset();
    test_empty_pop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
